// File: rtl/ex_pipe_ctrl.sv
// Execute-pipe sequencer: per-stage valid/ROB/exception tracking, stage load enables,
// and ROB completion arbitration (pipe tail over ALU). Optional macro: EX_PIPE_STALL_CNT_EN.
module ex_pipe_ctrl #(
  parameter int N_STAGES  = 4,
  parameter int ROB_IDX_W = 4,
  parameter int EXC_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_mc_valid,
  output logic                 out_mc_ready,
  input  logic [ROB_IDX_W-1:0] in_mc_rob_idx,
  input  logic [EXC_W-1:0]     in_mc_exc,
  input  logic                 in_alu_valid,
  output logic                 out_alu_ready,
  input  logic [ROB_IDX_W-1:0] in_alu_rob_idx,
  input  logic [EXC_W-1:0]     in_alu_exc,
  input  logic                 in_flush,
  output logic [N_STAGES-1:0]  out_stage_en,
  output logic [N_STAGES-1:0]  out_stage_valid,
  output logic                 out_cmpl_valid,
  output logic                 out_cmpl_sel,
  output logic [ROB_IDX_W-1:0] out_cmpl_rob_idx,
  output logic [EXC_W-1:0]     out_cmpl_exc,
  input  logic                 in_cmpl_ready
`ifdef EX_PIPE_STALL_CNT_EN
  ,
  output logic [31:0]          out_stall_cnt
`endif
);

  logic [N_STAGES-1:0]  r_v;
  logic [ROB_IDX_W-1:0] r_rob [N_STAGES];
  logic [EXC_W-1:0]     r_exc [N_STAGES];

  logic                 w_mc_fire;
  logic [N_STAGES-1:0]  w_adv;
  logic                 w_issue;
  logic                 w_tail_v;

  assign w_tail_v  = r_v[N_STAGES-1];
  assign w_mc_fire = w_tail_v & in_cmpl_ready;

  // A stage advances if any stage at or beyond it is empty, or the tail drains.
  always_comb begin
    logic w_all_full;
    w_all_full = 1'b1;
    w_adv      = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      w_all_full = w_all_full & r_v[i];
      w_adv[i]   = ~w_all_full | w_mc_fire;
    end
  end

  assign out_mc_ready    = w_adv[0] & ~in_flush;
  assign w_issue         = in_mc_valid & out_mc_ready;
  assign out_stage_en    = w_adv;
  assign out_stage_valid = r_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
      for (int i = 0; i < N_STAGES; i++) begin
        r_rob[i] <= '0;
        r_exc[i] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_v[0]   <= w_issue;
        r_rob[0] <= in_mc_rob_idx;
        r_exc[0] <= in_mc_exc;
      end
      for (int i = 1; i < N_STAGES; i++) begin
        if (w_adv[i]) begin
          r_v[i]   <= r_v[i-1];
          r_rob[i] <= r_rob[i-1];
          r_exc[i] <= r_exc[i-1];
        end
      end
      // Flush overrides any shift or issue on the valid bits only.
      if (in_flush) r_v <= '0;
    end
  end

  assign out_cmpl_valid   = w_tail_v | in_alu_valid;
  assign out_cmpl_sel     = w_tail_v;
  assign out_cmpl_rob_idx = w_tail_v ? r_rob[N_STAGES-1] : in_alu_rob_idx;
  assign out_cmpl_exc     = w_tail_v ? r_exc[N_STAGES-1] : in_alu_exc;
  assign out_alu_ready    = in_cmpl_ready & ~w_tail_v;

`ifdef EX_PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (w_tail_v & ~in_cmpl_ready) | (in_alu_valid & ~out_alu_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign out_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Directed self-checking bench for ex_pipe_ctrl (N_STAGES=4); inputs driven 1ns after
// the rising edge, outputs sampled on the falling edge.
module tb_ex_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_mc_valid;
  logic       out_mc_ready;
  logic [3:0] in_mc_rob_idx;
  logic [2:0] in_mc_exc;
  logic       in_alu_valid;
  logic       out_alu_ready;
  logic [3:0] in_alu_rob_idx;
  logic [2:0] in_alu_exc;
  logic       in_flush;
  logic [3:0] out_stage_en;
  logic [3:0] out_stage_valid;
  logic       out_cmpl_valid;
  logic       out_cmpl_sel;
  logic [3:0] out_cmpl_rob_idx;
  logic [2:0] out_cmpl_exc;
  logic       in_cmpl_ready;
`ifdef EX_PIPE_STALL_CNT_EN
  logic [31:0] out_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_pipe_ctrl #(.N_STAGES(4), .ROB_IDX_W(4), .EXC_W(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_mc_valid      (in_mc_valid),
    .out_mc_ready     (out_mc_ready),
    .in_mc_rob_idx    (in_mc_rob_idx),
    .in_mc_exc        (in_mc_exc),
    .in_alu_valid     (in_alu_valid),
    .out_alu_ready    (out_alu_ready),
    .in_alu_rob_idx   (in_alu_rob_idx),
    .in_alu_exc       (in_alu_exc),
    .in_flush         (in_flush),
    .out_stage_en     (out_stage_en),
    .out_stage_valid  (out_stage_valid),
    .out_cmpl_valid   (out_cmpl_valid),
    .out_cmpl_sel     (out_cmpl_sel),
    .out_cmpl_rob_idx (out_cmpl_rob_idx),
    .out_cmpl_exc     (out_cmpl_exc),
    .in_cmpl_ready    (in_cmpl_ready)
`ifdef EX_PIPE_STALL_CNT_EN
    ,
    .out_stall_cnt    (out_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    in_mc_valid    = 1'b0;
    in_mc_rob_idx  = '0;
    in_mc_exc      = '0;
    in_alu_valid   = 1'b0;
    in_alu_rob_idx = '0;
    in_alu_exc     = '0;
    in_flush       = 1'b0;
    in_cmpl_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({out_stage_valid, out_stage_en, out_mc_ready, out_cmpl_valid} !== {4'b0000, 4'b1111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got v=%b en=%b rdy=%b cv=%b exp v=0000 en=1111 rdy=1 cv=0",
               out_stage_valid, out_stage_en, out_mc_ready, out_cmpl_valid);
    end
    in_alu_valid   = 1'b1;
    in_alu_rob_idx = 4'd9;
    in_alu_exc     = 3'd2;
    #1;
    checks++;
    if ({out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_cmpl_exc, out_alu_ready} !== {1'b1, 1'b0, 4'd9, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL alu_only got cv=%b sel=%b rob=%0d exc=%0d ar=%b exp cv=1 sel=0 rob=9 exc=2 ar=1",
               out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_cmpl_exc, out_alu_ready);
    end
    in_cmpl_ready = 1'b0;
    #1;
    checks++;
    if (out_alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL alu_not_ready got ar=%b exp 0", out_alu_ready);
    end
    tick();
    in_alu_valid  = 1'b0;
    in_cmpl_ready = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    in_mc_valid   = 1'b1;
    in_mc_rob_idx = 4'd3;
    in_mc_exc     = 3'd0;
    @(negedge clk);
    checks++;
    if (out_mc_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_accept got rdy=%b exp 1", out_mc_ready);
    end
    tick();
    in_mc_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({out_stage_valid, out_cmpl_valid, out_mc_ready} !== {4'(1 << (c - 1)), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL single_travel c=%0d got v=%b cv=%b rdy=%b exp v=%b cv=0 rdy=1",
                 c, out_stage_valid, out_cmpl_valid, out_mc_ready, 4'(1 << (c - 1)));
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_mc_ready} !== {1'b1, 1'b1, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL single_cmpl got cv=%b sel=%b rob=%0d rdy=%b exp cv=1 sel=1 rob=3 rdy=1",
               out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_mc_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      in_mc_valid   = (c < 5);
      in_mc_rob_idx = 4'(c + 1);
      in_mc_exc     = 3'(c);
      @(negedge clk);
      checks++;
      if (c >= 4 && c <= 8) begin
        if ({out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_cmpl_exc, out_mc_ready} !==
            {1'b1, 1'b1, 4'(c - 3), 3'(c - 4), 1'b1}) begin
          errors++;
          $display("FAIL b2b_cmpl c=%0d got cv=%b sel=%b rob=%0d exc=%0d rdy=%b exp cv=1 sel=1 rob=%0d exc=%0d rdy=1",
                   c, out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_cmpl_exc, out_mc_ready, c - 3, c - 4);
        end
      end else begin
        if ({out_cmpl_valid, out_mc_ready} !== {1'b0, 1'b1}) begin
          errors++;
          $display("FAIL b2b_idle c=%0d got cv=%b rdy=%b exp cv=0 rdy=1", c, out_cmpl_valid, out_mc_ready);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_cmpl_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_mc_valid   = 1'b1;
      in_mc_rob_idx = 4'(c + 1);
      tick();
    end
    in_mc_valid = 1'b0;
    for (int c = 4; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if ({out_stage_valid, out_stage_en, out_mc_ready, out_cmpl_valid, out_cmpl_rob_idx} !==
          {4'b1111, 4'b0000, 1'b0, 1'b1, 4'd1}) begin
        errors++;
        $display("FAIL bp_hold c=%0d got v=%b en=%b rdy=%b cv=%b rob=%0d exp v=1111 en=0000 rdy=0 cv=1 rob=1",
                 c, out_stage_valid, out_stage_en, out_mc_ready, out_cmpl_valid, out_cmpl_rob_idx);
      end
      tick();
    end
    in_cmpl_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx} !== {1'b1, 1'b1, 4'(k + 1)}) begin
        errors++;
        $display("FAIL bp_drain k=%0d got cv=%b sel=%b rob=%0d exp cv=1 sel=1 rob=%0d",
                 k, out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, k + 1);
      end
      if (k == 0) begin
        checks++;
        if (out_stage_en !== 4'b1111) begin
          errors++;
          $display("FAIL bp_release_en got en=%b exp 1111", out_stage_en);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (out_cmpl_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got cv=%b exp 0", out_cmpl_valid);
    end
    tick();
  endtask

  task automatic test_arbitration();
    do_reset();
    in_mc_valid   = 1'b1;
    in_mc_rob_idx = 4'd7;
    in_mc_exc     = 3'd3;
    tick();
    in_mc_valid = 1'b0;
    tick();
    tick();
    tick();
    in_alu_valid   = 1'b1;
    in_alu_rob_idx = 4'd9;
    in_alu_exc     = 3'd5;
    @(negedge clk);
    checks++;
    if ({out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_cmpl_exc, out_alu_ready} !==
        {1'b1, 1'b1, 4'd7, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL arb_tail got cv=%b sel=%b rob=%0d exc=%0d ar=%b exp cv=1 sel=1 rob=7 exc=3 ar=0",
               out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_cmpl_exc, out_alu_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_cmpl_exc, out_alu_ready} !==
        {1'b1, 1'b0, 4'd9, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL arb_alu got cv=%b sel=%b rob=%0d exc=%0d ar=%b exp cv=1 sel=0 rob=9 exc=5 ar=1",
               out_cmpl_valid, out_cmpl_sel, out_cmpl_rob_idx, out_cmpl_exc, out_alu_ready);
    end
    tick();
    in_alu_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    in_mc_valid   = 1'b1;
    in_mc_rob_idx = 4'd1;
    tick();
    in_mc_valid = 1'b0;
    tick();
    in_mc_valid   = 1'b1;
    in_mc_rob_idx = 4'd2;
    tick();
    in_mc_valid = 1'b0;
    tick();
    in_flush      = 1'b1;
    in_mc_valid   = 1'b1;
    in_mc_rob_idx = 4'd6;
    @(negedge clk);
    checks++;
    if ({out_stage_valid, out_mc_ready, out_cmpl_valid, out_cmpl_rob_idx} !== {4'b1010, 1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL flush_cycle got v=%b rdy=%b cv=%b rob=%0d exp v=1010 rdy=0 cv=1 rob=1",
               out_stage_valid, out_mc_ready, out_cmpl_valid, out_cmpl_rob_idx);
    end
    tick();
    in_flush    = 1'b0;
    in_mc_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({out_stage_valid, out_cmpl_valid} !== {4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL flush_after c=%0d got v=%b cv=%b exp v=0000 cv=0", c, out_stage_valid, out_cmpl_valid);
      end
      tick();
    end
  endtask

`ifdef EX_PIPE_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    in_cmpl_ready = 1'b0;
    in_mc_valid   = 1'b1;
    in_mc_rob_idx = 4'd1;
    tick();
    in_mc_valid = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    @(negedge clk);
    checks++;
    if ({out_stall_cnt, out_stage_valid[3]} !== {32'd5, 1'b1}) begin
      errors++;
      $display("FAIL stall_cnt got cnt=%0d tail=%b exp cnt=5 tail=1", out_stall_cnt, out_stage_valid[3]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_stall_cnt, out_stage_valid} !== {32'd0, 4'b0000}) begin
      errors++;
      $display("FAIL stall_reset got cnt=%0d v=%b exp cnt=0 v=0000", out_stall_cnt, out_stage_valid);
    end
    tick();
    in_cmpl_ready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_arbitration();
    test_flush();
`ifdef EX_PIPE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
